crc_16_check: RTL and testbench



---
 rtl/crc_16_check_if.sv | 15 +
 rtl/crc_16_check.sv | 105 ++++++++++
 tb/tb_crc_16_check.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/crc_16_check_if.sv
// crc_16_check_if: serial symbol stream in, CRC check results out
interface crc_16_check_if;
  logic        enable;
  logic        data_in;
  logic        crc_phase;
  logic        crc_done;
  logic        crc_ok;
  logic        crc_err;
  logic        frame_err;
  logic [15:0] crc_calc;
  modport master (output enable, data_in, crc_phase,
                  input crc_done, crc_ok, crc_err, frame_err, crc_calc);
  modport slave  (input enable, data_in, crc_phase,
                  output crc_done, crc_ok, crc_err, frame_err, crc_calc);
endinterface

// File: rtl/crc_16_check.sv
// crc_16_check: serial CRC-16 (0x8005, seed FFFF) checker over 10-bit framed symbols
module crc_16_check (
  input logic      clk,
  input logic      reset,
  crc_16_check_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DONE} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] crc_reg, crc_n;
  logic [4:0]  crc_bits, bits_n;
  logic        sym_crc, sym_n, mismatch, mis_n, ferr, ferr_n;
  logic        done_q, done_n, ok_q, ok_n, err_q, err_n, armed, armed_n, fb;
  // next-state and datapath: symbol framing, CRC accumulate/compare, completion
  always_comb begin
    state_n = state;
    cnt_n   = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
    sym_n   = sym_crc;
    crc_n   = crc_reg;
    mis_n   = mismatch;
    bits_n  = crc_bits;
    ferr_n  = ferr;
    done_n  = 1'b0;
    ok_n    = ok_q;
    err_n   = err_q;
    armed_n = armed | !bus.enable;
    fb      = crc_reg[15] ^ bus.data_in;
    if (!bus.enable) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      sym_n   = 1'b0;
      crc_n   = 16'hFFFF;
      mis_n   = 1'b0;
      bits_n  = 5'd0;
      ferr_n  = 1'b0;
      ok_n    = 1'b0;
      err_n   = 1'b0;
    end else if (state == IDLE && !armed) begin
      cnt_n = 4'd0;
    end else if (state != DONE) begin
      if (cnt == 4'd0) begin
        sym_n = bus.crc_phase;
        if (state == CHECK && !bus.crc_phase) begin
          done_n  = 1'b1;
          ok_n    = 1'b0;
          err_n   = 1'b1;
          crc_n   = 16'hFFFF;
          mis_n   = 1'b0;
          bits_n  = 5'd0;
          ferr_n  = bus.data_in;
          state_n = PAYLOAD;
        end else begin
          ferr_n  = ferr | bus.data_in;
          state_n = bus.crc_phase ? CHECK : PAYLOAD;
        end
      end else if (cnt == 4'd9) begin
        ferr_n = ferr | !bus.data_in;
        if (state == CHECK && crc_bits == 5'd16) begin
          state_n = DONE;
          done_n  = 1'b1;
          ok_n    = !mismatch && !ferr_n;
          err_n   = !ok_n;
        end
      end else if (sym_crc) begin
        mis_n  = mismatch | (bus.data_in != crc_reg[15]);
        crc_n  = {crc_reg[14:0], 1'b0};
        bits_n = crc_bits + 5'd1;
      end else begin
        crc_n = {crc_reg[14] ^ fb, crc_reg[13:2], crc_reg[1] ^ fb, crc_reg[0], fb};
      end
    end
  end
  // state and result registers; armed forces a fresh enable rise after reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sym_crc  <= 1'b0;
      crc_reg  <= 16'hFFFF;
      mismatch <= 1'b0;
      crc_bits <= 5'd0;
      ferr     <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sym_crc  <= sym_n;
      crc_reg  <= crc_n;
      mismatch <= mis_n;
      crc_bits <= bits_n;
      ferr     <= ferr_n;
      done_q   <= done_n;
      ok_q     <= ok_n;
      err_q    <= err_n;
      armed    <= armed_n;
    end
  assign bus.crc_done  = done_q;
  assign bus.crc_ok    = ok_q;
  assign bus.crc_err   = err_q;
  assign bus.frame_err = ferr;
  assign bus.crc_calc  = crc_reg;
endmodule

// File: tb/tb_crc_16_check.sv
// tb_crc_16_check: scoreboard bench with bytewise CRC reference model
module tb_crc_16_check;
  logic clk = 1'b0;
  logic reset = 1'b0;
  crc_16_check_if bif();
  crc_16_check dut (.clk(clk), .reset(reset), .bus(bif));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];
  logic e;
  logic [7:0] p[$];
  logic [7:0] nb;
  logic [15:0] c;
  int n, bs, bp;
  logic flip;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] r = 16'hFFFF;
    foreach (q[i]) begin
      r ^= {q[i], 8'h00};
      repeat (8) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic bit_out(input logic ph, input logic d);
    bif.crc_phase = ph;
    bif.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic ph, input logic [7:0] b, input logic sb, input logic pb);
    bit_out(ph, sb);
    for (int i = 7; i >= 0; i--) bit_out(1'($urandom_range(1)), b[i]);
    bit_out(1'($urandom_range(1)), pb);
  endtask

  task automatic frame(input logic [7:0] q[$], input logic [15:0] tx, input int s, input int t, input logic ok);
    int m = q.size();
    logic fe = 1'b0;
    for (int i = 0; i < m; i++) if (i == s || i == t) fe = 1'b1;
    bif.enable = 1'b1;
    exp_q.push_back(ok);
    for (int i = 0; i < m; i++) sym(1'b0, q[i], 1'(i == s), 1'(i != t));
    @(negedge clk);
    check("crc_calc_payload", bif.crc_calc, crc_of(q));
    check("frame_err_payload", 16'(bif.frame_err), 16'(fe));
    sym(1'b1, tx[15:8], 1'(m == s), 1'(m != t));
    sym(1'b1, tx[7:0], 1'(m + 1 == s), 1'(m + 1 != t));
    @(negedge clk);
    check("done_latency", 16'(bif.crc_done), 16'd1);
    bif.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic abort(input logic [7:0] q[$]);
    bif.enable = 1'b1;
    foreach (q[i]) sym(1'b0, q[i], 1'b0, 1'b1);
    sym(1'b1, 8'($urandom), 1'b0, 1'b1);
    bif.enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_crc_calc", bif.crc_calc, 16'hFFFF);
    check("abort_ok", 16'(bif.crc_ok), 16'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every crc_done must match the oldest expected result
  always @(negedge clk)
    if (reset && bif.crc_done !== 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_done", 16'(bif.crc_done), 16'd0);
      else begin
        e = exp_q.pop_front();
        check("crc_ok", 16'(bif.crc_ok), 16'(e));
        check("crc_err", 16'(bif.crc_err), 16'(!e));
      end
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bif.enable = 1'b0;
    bif.data_in = 1'b0;
    bif.crc_phase = 1'b0;
    @(negedge clk);
    check("rst_done", 16'(bif.crc_done), 16'd0);
    check("rst_ok", 16'(bif.crc_ok), 16'd0);
    check("rst_err", 16'(bif.crc_err), 16'd0);
    check("rst_frame_err", 16'(bif.frame_err), 16'd0);
    check("rst_crc_calc", bif.crc_calc, 16'hFFFF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    p.delete();
    frame(p, 16'hFFFF, -1, -1, 1'b1);
    p.push_back(8'h00);
    frame(p, 16'hFD02, -1, -1, 1'b1);
    frame(p, 16'hFD03, -1, -1, 1'b0);
    frame(p, 16'hFD02, -1, 0, 1'b0);
    bif.enable = 1'b1;
    exp_q.push_back(1'b0);
    sym(1'b0, 8'h00, 1'b0, 1'b1);
    sym(1'b1, 8'hFD, 1'b0, 1'b1);
    bit_out(1'b0, 1'b0);
    @(negedge clk);
    check("trunc_done", 16'(bif.crc_done), 16'd1);
    check("trunc_reseed", bif.crc_calc, 16'hFFFF);
    nb = 8'($urandom);
    for (int i = 7; i >= 0; i--) bit_out(1'($urandom_range(1)), nb[i]);
    bit_out(1'($urandom_range(1)), 1'b1);
    p.delete();
    p.push_back(nb);
    c = crc_of(p);
    @(negedge clk);
    check("trunc_new_payload", bif.crc_calc, c);
    exp_q.push_back(1'b1);
    sym(1'b1, c[15:8], 1'b0, 1'b1);
    sym(1'b1, c[7:0], 1'b0, 1'b1);
    bif.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bif.enable = 1'b1;
    p.delete();
    p.push_back(8'($urandom));
    c = crc_of(p);
    sym(1'b0, p[0], 1'b0, 1'b1);
    sym(1'b1, c[15:8], 1'b0, 1'b1);
    bit_out(1'b1, 1'b0);
    for (int i = 7; i >= 4; i--) bit_out(1'b1, c[i]);
    #2;
    reset = 1'b0;
    #1;
    check("arst_done", 16'(bif.crc_done), 16'd0);
    check("arst_ok", 16'(bif.crc_ok), 16'd0);
    check("arst_err", 16'(bif.crc_err), 16'd0);
    check("arst_frame_err", 16'(bif.frame_err), 16'd0);
    check("arst_crc_calc", bif.crc_calc, 16'hFFFF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) bit_out(1'($urandom_range(1)), 1'($urandom_range(1)));
    check("arst_stay_idle", bif.crc_calc, 16'hFFFF);
    bif.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int f = 0; f < 40; f++) begin
      p.delete();
      n = int'($urandom_range(4));
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      c = crc_of(p);
      flip = ($urandom_range(3) == 0);
      if (flip) c ^= 16'(1) << $urandom_range(15);
      bs = ($urandom_range(4) == 0) ? int'($urandom_range(n + 1)) : -1;
      bp = ($urandom_range(4) == 0) ? int'($urandom_range(n + 1)) : -1;
      if ($urandom_range(7) == 0) abort(p);
      else frame(p, c, bs, bp, !flip && bs < 0 && bp < 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("pending_done", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
